// File: rtl/shiftreg_config_target.sv
// Serial configuration receiver: deserializes a bit stream into a dynamic or
// static shadow register and commits it to parallel latch outputs on a validated strobe.
module shiftreg_config_target #(
    parameter int SIZESRSTAT = 88,
    parameter int SIZESRDYN  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  SIN,
    input  logic                  SHIFT_EN,
    input  logic                  SELDYN,
    input  logic                  SELSTAT,
    input  logic                  LATCH,
    output logic                  SOUT,
    output logic [SIZESRDYN-1:0]  DYNLATCH,
    output logic [SIZESRSTAT-1:0] STATLATCH,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERR
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic [6:0] L_DYN_LEN  = 7'(SIZESRDYN);
    localparam logic [6:0] L_STAT_LEN = 7'(SIZESRSTAT);
    localparam logic [6:0] L_CNT_MAX  = 7'd127;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [SIZESRDYN-1:0]    r_dynreg;
    logic [SIZESRSTAT-1:0]   r_statreg;
    logic [SIZESRDYN-1:0]    r_dynlatch;
    logic [SIZESRSTAT-1:0]   r_statlatch;
    logic [6:0]              r_cnt;
    logic                    r_tgt;
    logic                    r_sout;
    logic                    r_done;
    logic                    r_err;

    logic                    w_sel_valid;
    logic                    w_sel_tgt;
    logic                    w_cnt_match;
    logic                    w_start;
    logic                    w_shift;
    logic                    w_shift_tgt;
    logic                    w_latch_dyn;
    logic                    w_latch_stat;
    logic                    w_done;
    logic                    w_err;

    assign w_sel_valid = SELDYN ^ SELSTAT;
    assign w_sel_tgt   = SELSTAT;
    assign w_cnt_match = r_tgt ? (r_cnt == L_STAT_LEN) : (r_cnt == L_DYN_LEN);
    // The entry cycle shifts into the freshly selected target before r_tgt is updated.
    assign w_shift_tgt = w_start ? w_sel_tgt : r_tgt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_shift      = 1'b0;
        w_latch_dyn  = 1'b0;
        w_latch_stat = 1'b0;
        w_done       = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (LATCH) begin
                    w_err = 1'b1;
                end else if (SHIFT_EN) begin
                    if (w_sel_valid) begin
                        w_start      = 1'b1;
                        w_shift      = 1'b1;
                        w_state_next = ST_SHIFT;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (LATCH) begin
                    w_state_next = ST_IDLE;
                    if (SHIFT_EN || !w_cnt_match) begin
                        w_err = 1'b1;
                    end else begin
                        w_done       = 1'b1;
                        w_latch_dyn  = ~r_tgt;
                        w_latch_stat = r_tgt;
                    end
                end else if (SHIFT_EN) begin
                    if (w_sel_valid && (w_sel_tgt == r_tgt)) begin
                        w_shift = 1'b1;
                    end else begin
                        w_err        = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_dynreg    <= '0;
            r_statreg   <= '0;
            r_dynlatch  <= '0;
            r_statlatch <= '0;
            r_cnt       <= '0;
            r_tgt       <= 1'b0;
            r_sout      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= w_done;
            r_err  <= w_err;

            if (w_start) begin
                r_tgt <= w_sel_tgt;
                r_cnt <= 7'd1;
            end else if (w_shift && (r_cnt != L_CNT_MAX)) begin
                r_cnt <= r_cnt + 7'd1;
            end

            if (w_shift) begin
                if (w_shift_tgt) begin
                    r_statreg <= {r_statreg[SIZESRSTAT-2:0], SIN};
                    r_sout    <= r_statreg[SIZESRSTAT-1];
                end else begin
                    r_dynreg <= {r_dynreg[SIZESRDYN-2:0], SIN};
                    r_sout   <= r_dynreg[SIZESRDYN-1];
                end
            end

            if (w_latch_dyn) begin
                r_dynlatch <= r_dynreg;
            end
            if (w_latch_stat) begin
                r_statlatch <= r_statreg;
            end
        end
    end

    assign SOUT      = r_sout;
    assign DYNLATCH  = r_dynlatch;
    assign STATLATCH = r_statlatch;
    assign BUSY      = (r_state == ST_SHIFT);
    assign DONE      = r_done;
    assign ERR       = r_err;

endmodule
